// File: rtl/bram_read_streamer_if.sv
// Request/response stream bundle for bram_read_streamer.
// The slave modport is the streamer's view; master is the requester/consumer side.
interface bram_read_streamer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 36
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [ADDR_WIDTH-1:0] resp_addr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_addr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_addr
    );
endinterface

// File: rtl/bram_read_streamer.sv
// Turns the fixed 1-cycle BRAM read latency into a backpressured response stream.
// Credits (FIFO count plus the read in flight) gate request acceptance so data is never dropped.
module bram_read_streamer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 36,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    bram_read_streamer_if.slave   bus,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

    localparam logic [CNT_W:0]   OCC_LIMIT  = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);

    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_addr;
    logic [ENTRY_W-1:0]    fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        occ;
    logic                  accept;
    logic                  read_accept;
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    // Occupancy uses registered state only, so req_ready never depends on this cycle's inputs.
    always_comb begin
        occ         = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        accept      = bus.req_valid && bus.req_ready;
        read_accept = accept && !bus.req_we;
        push        = inflight;
        pop         = bus.resp_valid && bus.resp_ready;
        bram_en     = accept;
        bram_we     = accept && bus.req_we;
        bram_addr   = bus.req_addr;
        bram_di     = bus.req_wdata;
    end

    assign bus.req_ready                 = !reset && (occ < OCC_LIMIT);
    assign bus.resp_valid                = (count != '0);
    assign {bus.resp_data, bus.resp_addr} = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= read_accept;
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (read_accept) begin
            inflight_addr <= bus.req_addr;
        end
        if (push) begin
            fifo_mem[wr_ptr] <= {bram_do, inflight_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!push || pop || (count < COUNT_FULL));
        end
    end
endmodule

// File: tb/tb_bram_read_streamer.sv
// Scoreboard bench for bram_read_streamer: a behavioural BRAM, a shadow memory
// and a queue of expected responses checked every cycle on the falling edge.
module tb_bram_read_streamer;
    localparam int AW    = 10;
    localparam int DW    = 36;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            ready_cycle;
    } sb_entry_t;

    logic          clk;
    logic          reset;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_di;
    logic [DW-1:0] bram_do;

    logic [DW-1:0] bram_mem [1 << AW];
    logic [DW-1:0] shadow   [1 << AW];
    sb_entry_t     sb [$];

    int checks       = 0;
    int failures     = 0;
    int cycle        = 0;
    int stall_cycles = 0;

    bram_read_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_read_streamer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .bram_en(bram_en),
        .bram_we(bram_we),
        .bram_addr(bram_addr),
        .bram_di(bram_di),
        .bram_do(bram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single port of the true-dual-port BRAM with 1-cycle read latency.
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                bram_mem[bram_addr] <= bram_di;
            end else begin
                bram_do <= bram_mem[bram_addr];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    // Falling-edge monitor: inputs are stable here and the handshake completes at the next rising edge.
    always @(negedge clk) begin
        logic      exp_ready;
        logic      exp_valid;
        logic      acc;
        sb_entry_t ent;
        cycle = cycle + 1;
        if (reset) begin
            checkOutput("req_ready_in_reset", 64'(bus.req_ready), 64'(0));
            checkOutput("bram_en_in_reset", 64'(bram_en), 64'(0));
            sb.delete();
        end else begin
            exp_ready = (sb.size() < DEPTH);
            exp_valid = (sb.size() != 0) && (sb[0].ready_cycle <= cycle);
            checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            checkOutput("resp_valid", 64'(bus.resp_valid), 64'(exp_valid));
            if (exp_valid) begin
                checkOutput("resp_data", 64'(bus.resp_data), 64'(sb[0].data));
                checkOutput("resp_addr", 64'(bus.resp_addr), 64'(sb[0].addr));
                if (bus.resp_ready) begin
                    ent = sb.pop_front();
                end
            end
            acc = bus.req_valid && exp_ready;
            checkOutput("bram_en", 64'(bram_en), 64'(acc));
            if (acc) begin
                checkOutput("bram_we", 64'(bram_we), 64'(bus.req_we));
                checkOutput("bram_addr", 64'(bram_addr), 64'(bus.req_addr));
                if (bus.req_we) begin
                    checkOutput("bram_di", 64'(bram_di), 64'(bus.req_wdata));
                    shadow[bus.req_addr] = bus.req_wdata;
                end else begin
                    ent.addr        = bus.req_addr;
                    ent.data        = shadow[bus.req_addr];
                    ent.ready_cycle = cycle + 2;
                    sb.push_back(ent);
                end
            end else begin
                checkOutput("bram_we_idle", 64'(bram_we), 64'(0));
            end
        end
    end

    // Holds one request until accepted; after a short stall the consumer is released to avoid deadlock.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bit done = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        for (int n = 0; n < 32 && !done; n++) begin
            @(negedge clk);
            done = bus.req_ready;
            if (!done) begin
                stall_cycles++;
                if (n >= 2) bus.resp_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!done) checkOutput("req_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic idleCycles(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain();
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        for (int n = 0; n < 40 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'(0));
        idleCycles(2);
    endtask

    initial begin
        int accepted;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idleCycles(1);

        // Write then read back one location.
        bus.resp_ready = 1'b1;
        applyStimulus(1'b1, 10'h005, 36'h123456789);
        applyStimulus(1'b0, 10'h005, '0);
        waitDrain();

        // Preload and stream eight back-to-back reads.
        stall_cycles = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, AW'(i), DW'(36'h100 + i));
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, AW'(i), '0);
        checkOutput("stream_no_stall", 64'(stall_cycles), 64'(0));
        waitDrain();

        // Consumer stalled: credits must run out after DEPTH accepts.
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        accepted       = 0;
        for (int k = 0; k < 8; k++) begin
            bus.req_addr = AW'(accepted);
            @(negedge clk);
            if (bus.req_ready) accepted++;
            @(posedge clk);
            #1;
        end
        checkOutput("accepted_while_stalled", 64'(accepted), 64'(DEPTH));
        waitDrain();

        // Alternating write/read to the top address.
        stall_cycles = 0;
        applyStimulus(1'b1, 10'h3FF, 36'hA);
        applyStimulus(1'b0, 10'h3FF, '0);
        applyStimulus(1'b1, 10'h3FF, 36'hB);
        applyStimulus(1'b0, 10'h3FF, '0);
        checkOutput("alt_no_stall", 64'(stall_cycles), 64'(0));
        waitDrain();

        // Reset with one read in flight and two responses queued.
        bus.resp_ready = 1'b0;
        applyStimulus(1'b0, 10'h001, '0);
        applyStimulus(1'b0, 10'h002, '0);
        applyStimulus(1'b0, 10'h003, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.resp_ready = 1'b1;
        idleCycles(4);

        // Fill to count=DEPTH-1 with a read in flight, then push and pop together.
        bus.resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, AW'(i + 4), '0);
        bus.resp_ready = 1'b1;
        idleCycles(1);
        waitDrain();

        // Mixed traffic with random backpressure.
        for (int i = 0; i < 60; i++) begin
            bus.resp_ready = ($urandom_range(0, 9) < 7);
            applyStimulus(1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), DW'($urandom));
        end
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
